div4_vector_seq: RTL and testbench
==================================

Name: div4_vector_seq

Overview:
- Sequential divider; the inverse of the mul4_vector limb multiplier.
- Divides a 64-bit dividend, presented as four 16-bit limbs y3..y0 (y3 most significant), by a 32-bit divisor b1:b0.
- Returns a 32-bit quotient q1:q0 and a 32-bit remainder r1:r0.
- Radix-2 restoring algorithm, one quotient bit per cycle. Valid/ready handshakes on both input and output.
- Used to cross-check multiplier candidates and to undo their products in the evaluation harness.

Parameters:
- LIMB_W, 16, limb width in bits. Dividend is 4*LIMB_W bits; divisor, quotient and remainder are 2*LIMB_W bits; iteration count N = 2*LIMB_W.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- y3, y2, y1, y0  input  LIMB_W each  dividend limbs, y3 most significant
- b1, b0  input  LIMB_W each  divisor limbs, b1 most significant
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q1, q0  output  LIMB_W each  quotient limbs
- r1, r0  output  LIMB_W each  remainder limbs
- err_dz  output  1  divisor was zero
- err_ovf  output  1  quotient does not fit in 2*LIMB_W bits

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q1=q0=r1=r0=0, err_dz=err_ovf=0.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: a transfer occurs when in_valid && in_ready. Operands are registered on that edge; later input changes are ignored.
- Decode at accept, in priority order:
  - Divisor b1:b0 == 0 → DONE with err_dz=1, q=all ones, r=y1:y0.
  - Else y3:y2 >= b1:b0 → DONE with err_ovf=1, q=all ones, r=0.
  - Else → RUN, with iteration counter=0, partial remainder R (2*LIMB_W+1 bits) = y3:y2, and shift register S = y1:y0.
- RUN, one iteration per cycle:
  - T = {R[2*LIMB_W-1:0], S msb}; S shifts left by 1.
  - If T >= D: R = T-D and shift in quotient bit 1. Else R = T and shift in 0.
  - After iteration N-1 → DONE, with q = collected bits and r = R[2*LIMB_W-1:0].
- Latency from the accept edge to out_valid:
  - Normal operation: N+1 cycles (33 cycles for LIMB_W=16).
  - Error cases: 1 cycle.
- DONE:
  - out_valid and all result/flag outputs stay stable until out_valid && out_ready.
  - On that edge, go to IDLE with out_valid=0. Result outputs hold their last values; flags keep their values until the next result.
  - in_ready rises the cycle after the output handshake. There is no input/output overlap, so throughput is one division per N+2 cycles minimum.
- out_ready while not in DONE: ignored.
- in_valid while not in IDLE: ignored, no transfer.
- rst mid-RUN or in DONE: immediate return to reset values. The in-flight result is discarded and never emitted.
- Arithmetic: unsigned only. The compare/subtract is 2*LIMB_W+1 bits wide so the shifted-out MSB is not lost.
- err_dz and err_ovf are never both 1.

Optional Feature:
- Macro: DIV4_VECTOR_STATS_EN.
- When defined, the block adds:
  - Output port div_count (16 bits): saturating count of completed output handshakes, reset to 0, holds at 0xFFFF.
  - Output port err_count (16 bits): saturating count of handshakes with err_dz or err_ovf set.
- When undefined, neither port nor counter logic exists and the behaviour is otherwise identical.

Test Plan:
- y=0x0000_0000_0000_0064, b=0x0000_0007 → q1=0, q0=0x000E, r1=0, r0=0x0002, no flags; out_valid exactly 33 cycles after accept.
- y=0xFFFF_FFFE_0000_0001, b=0xFFFF_FFFF → q=0xFFFF_FFFF, r=0, no flags. Separately, y=0x0000_0001_0000_0000, b=0x0001_0000 → q1=0x0001, q0=0, r=0.
- b=0, y1=0x1234, y0=0x5678 → err_dz=1, q=0xFFFF_FFFF, r1=0x1234, r0=0x5678; out_valid 1 cycle after accept.
- y3:y2=0x0000_0005, b=0x0000_0005 → err_ovf=1, q=0xFFFF_FFFF, r=0; 1-cycle latency.
- Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, in_valid pulses not accepted. Raise out_ready → out_valid falls and in_ready=1 on the next cycle.
- Assert rst at RUN iteration 10 → out_valid=0 and in_ready=1 immediately. A new operation afterwards completes correctly with no stale output. With DIV4_VECTOR_STATS_EN, div_count is unchanged by the aborted operation.

Source files
------------

// File: rtl/div4_vector_seq.sv
// Sequential radix-2 restoring divider: 4-limb dividend by 2-limb divisor, valid/ready on both sides.
// Define DIV4_VECTOR_STATS_EN to add saturating div_count/err_count handshake counters.
module div4_vector_seq #(
   parameter int unsigned LIMB_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LIMB_W-1:0] y3,
   input  logic [LIMB_W-1:0] y2,
   input  logic [LIMB_W-1:0] y1,
   input  logic [LIMB_W-1:0] y0,
   input  logic [LIMB_W-1:0] b1,
   input  logic [LIMB_W-1:0] b0,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LIMB_W-1:0] q1,
   output logic [LIMB_W-1:0] q0,
   output logic [LIMB_W-1:0] r1,
   output logic [LIMB_W-1:0] r0,
   output logic              err_dz,
   output logic              err_ovf
`ifdef DIV4_VECTOR_STATS_EN
   ,
   output logic [15:0]       div_count,
   output logic [15:0]       err_count
`endif
);

   localparam int unsigned W  = 2 * LIMB_W;
   localparam int unsigned N  = W;
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [W-1:0]  div_in, y_hi, y_lo;
   logic [W-1:0]  d_work, s_work, r_work;
   logic [CW-1:0] cnt;
   logic [W-1:0]  q_res, r_res;
   logic [W:0]    t;
   logic [W-1:0]  r_step, q_step;
   logic          ge, dz, ovf, accept, last;

   assign div_in = {b1, b0};
   assign y_hi   = {y3, y2};
   assign y_lo   = {y1, y0};

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign dz        = (div_in == '0);
   assign ovf       = !dz && (y_hi >= div_in);

   // Partial remainder stays below the divisor, so W bits hold it; only T needs the extra bit.
   assign t      = {r_work, s_work[W-1]};
   assign ge     = (t >= {1'b0, d_work});
   assign r_step = ge ? W'(t - {1'b0, d_work}) : t[W-1:0];
   assign q_step = {s_work[W-2:0], ge};
   assign last   = (cnt == CW'(N - 1));

   assign {q1, q0} = q_res;
   assign {r1, r0} = r_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (dz || ovf) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Dividend low half shifts out of s_work's MSB while quotient bits fill its LSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_work  <= '0;
         s_work  <= '0;
         r_work  <= '0;
         cnt     <= '0;
         q_res   <= '0;
         r_res   <= '0;
         err_dz  <= 1'b0;
         err_ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dz) begin
                     q_res   <= '1;
                     r_res   <= y_lo;
                     err_dz  <= 1'b1;
                     err_ovf <= 1'b0;
                  end else if (ovf) begin
                     q_res   <= '1;
                     r_res   <= '0;
                     err_dz  <= 1'b0;
                     err_ovf <= 1'b1;
                  end else begin
                     d_work <= div_in;
                     r_work <= y_hi;
                     s_work <= y_lo;
                     cnt    <= '0;
                  end
               end
            end
            RUN: begin
               r_work <= r_step;
               s_work <= q_step;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  q_res   <= q_step;
                  r_res   <= r_step;
                  err_dz  <= 1'b0;
                  err_ovf <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DIV4_VECTOR_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_count <= '0;
         err_count <= '0;
      end else if (out_valid && out_ready) begin
         if (div_count != '1) begin
            div_count <= div_count + 1'b1;
         end
         if ((err_dz || err_ovf) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_div4_vector_seq.sv
// Scoreboard bench for div4_vector_seq: stimulus pushes 64/32-bit arithmetic expectations, a monitor pops on output handshakes.
module tb_div4_vector_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] y3 = '0, y2 = '0, y1 = '0, y0 = '0, b1 = '0, b0 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] q1, q0, r1, r0;
   logic        err_dz, err_ovf;
`ifdef DIV4_VECTOR_STATS_EN
   logic [15:0] div_count, err_count;
   int          exp_div = 0, exp_err = 0;
`endif

   div4_vector_seq #(.LIMB_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .y3(y3), .y2(y2), .y1(y1), .y0(y0), .b1(b1), .b0(b0),
      .out_valid(out_valid), .out_ready(out_ready),
      .q1(q1), .q0(q0), .r1(r1), .r0(r0),
      .err_dz(err_dz), .err_ovf(err_ovf)
`ifdef DIV4_VECTOR_STATS_EN
      , .div_count(div_count), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic exp_t model(input logic [63:0] y, input logic [31:0] b);
      exp_t e;
      logic [63:0] bw;
      bw = {32'd0, b};
      e.dz = 1'b0; e.ovf = 1'b0;
      if (b == 32'd0) begin
         e.dz = 1'b1; e.q = 32'hFFFF_FFFF; e.r = y[31:0];
      end else if (y / bw > 64'h0000_0000_FFFF_FFFF) begin
         e.ovf = 1'b1; e.q = 32'hFFFF_FFFF; e.r = 32'd0;
      end else begin
         e.q = 32'(y / bw); e.r = 32'(y % bw);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {q1, q0, r1, r0}, '0);
            if ({q1, q0, r1, r0} === '0) $display("FAIL unexpected_output: got result with empty scoreboard, required none");
            if ({q1, q0, r1, r0} === '0) passed--;
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", {q1, q0}, e.q);
            chk("remainder", {r1, r0}, e.r);
            chk("err_dz", err_dz, e.dz);
            chk("err_ovf", err_ovf, e.ovf);
         end
      end
   end

   task automatic issue(input logic [63:0] y, input logic [31:0] b);
      chk("in_ready_before_issue", in_ready, 1'b1);
      {y3, y2, y1, y0} = y;
      {b1, b0} = b;
      in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(model(y, b));
      #1;
      in_valid = 1'b0;
      {y3, y2, y1, y0} = {$urandom, $urandom};
      {b1, b0} = $urandom;
   endtask

   task automatic recover();
      rst = 1'b1;
      #1;
      if (sb.size() > 0) void'(sb.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_op(input logic [63:0] y, input logic [31:0] b, input int hold);
      exp_t e;
      int lat;
      logic [65:0] snap;
      e = model(y, b);
      out_ready = 1'b0;
      issue(y, b);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, (e.dz || e.ovf) ? 1 : 33);
      if (!out_valid) begin
         recover();
         return;
      end
      snap = {q1, q0, r1, r0, err_dz, err_ovf};
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         {y3, y2, y1, y0} = {$urandom, $urandom};
         {b1, b0} = $urandom;
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("hold_stable", {q1, q0, r1, r0, err_dz, err_ovf, in_ready, out_valid}, {snap, 1'b0, 1'b1});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release", {out_valid, in_ready}, 2'b01);
      out_ready = 1'b0;
`ifdef DIV4_VECTOR_STATS_EN
      exp_div++;
      if (e.dz || e.ovf) exp_err++;
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b, yh;
      int sel;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_state", {in_ready, out_valid, q1, q0, r1, r0, err_dz, err_ovf}, {1'b1, 1'b0, 66'd0});

      run_op(64'h0000_0000_0000_0064, 32'h0000_0007, 0);
      run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1);
      run_op(64'h0000_0001_0000_0000, 32'h0001_0000, 0);
      run_op(64'hAAAA_BBBB_1234_5678, 32'h0000_0000, 2);
      run_op(64'h0000_0005_9999_0000, 32'h0000_0005, 0);
      run_op(64'h0000_0004_FFFF_FFFF, 32'h0000_0005, 0);
      run_op(64'h0000_0000_0000_0064, 32'h0000_0007, 10);

      // abort mid-computation
      out_ready = 1'b1;
      issue(64'h0123_4567_89AB_CDEF, 32'hF000_0001);
      repeat (11) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_reset", {in_ready, out_valid, q1, q0, r1, r0, err_dz, err_ovf}, {1'b1, 1'b0, 66'd0});
      void'(sb.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
`ifdef DIV4_VECTOR_STATS_EN
      exp_div = 0; exp_err = 0;
      chk("div_count_after_abort", div_count, 16'd0);
`endif
      run_op(64'h0000_0000_0001_0000, 32'h0000_0003, 0);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) b = 32'($urandom_range(1, 15));
         else b = $urandom;
         if (sel == 2 || b == 32'd0) yh = $urandom;
         else yh = $urandom % b;
         run_op({yh, 32'($urandom)}, b, $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
`ifdef DIV4_VECTOR_STATS_EN
      chk("div_count", div_count, exp_div);
      chk("err_count", err_count, exp_err);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
